// File: rtl/spi_sram_ctrl.sv
// spi_sram_ctrl: Wishbone-style word port to an SPI (mode 0) serial SRAM.
// A request sends one command byte (0x02 write, 0x03 read), then the byte
// address MSB first, then the data bytes. Reads always move a full word.
// Writes move only the span of bytes between the lowest and highest
// selected byte.
// Optional build macro: SPI_SRAM_BYTESWAP_EN. When it is defined, byte
// offset k maps to lane k (little-endian). When it is not defined, byte
// offset k maps to lane 3-k (big-endian, the order the bytes travel on the wire).
module spi_sram_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int ADDR_BYTES = 2,
    parameter int CLK_DIV    = 1,
    parameter int CSH_CYC    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cyc,
    input  logic [ADDR_W-1:0] adr,
    input  logic              we,
    input  logic [31:0]       dat_i,
    input  logic [3:0]        sel,
    output logic [31:0]       dat_o,
    output logic              ack,
    input  logic              spi_miso,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs_n
);

    localparam int BA_W     = 8 * ADDR_BYTES;
    localparam int HDR_BITS = 8 + BA_W;
    localparam int SH_W     = HDR_BITS + 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_GUARD = 3'd4;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] FULL_LAST = 9'(2 * CLK_DIV - 1);

    logic [2:0]      state;
    logic [8:0]      div_cnt;
    logic [6:0]      bit_cnt;
    logic [6:0]      nbits;
    logic [4:0]      grd_cnt;
    logic [SH_W-1:0] sh;
    logic [31:0]     rx;
    logic            we_q;

    logic [3:0]      off_sel;
    logic [31:0]     tx_word;
    logic [31:0]     rx_lanes;
    logic [1:0]      lo;
    logic [1:0]      hi;
    logic [1:0]      lo_eff;
    logic [2:0]      nbytes;
    logic [31:0]     tx_aligned;
    logic [BA_W-1:0] byte_addr;
    logic [SH_W-1:0] load;
    logic [6:0]      load_bits;

    // Map lanes to byte offsets, find the write span, and build the serial frame
    always_comb begin
`ifdef SPI_SRAM_BYTESWAP_EN
        off_sel  = sel;
        tx_word  = {dat_i[7:0], dat_i[15:8], dat_i[23:16], dat_i[31:24]};
        rx_lanes = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
`else
        off_sel  = {sel[0], sel[1], sel[2], sel[3]};
        tx_word  = dat_i;
        rx_lanes = rx;
`endif
        // tx_word / rx hold byte offset 0 in bits [31:24]
        lo = off_sel[0] ? 2'd0 : off_sel[1] ? 2'd1 : off_sel[2] ? 2'd2 : 2'd3;
        hi = off_sel[3] ? 2'd3 : off_sel[2] ? 2'd2 : off_sel[1] ? 2'd1 : 2'd0;
        lo_eff     = we ? lo : 2'd0;
        nbytes     = we ? (3'(hi) - 3'(lo) + 3'd1) : 3'd4;
        tx_aligned = we ? (tx_word << {lo, 3'b000}) : 32'h0;
        byte_addr  = BA_W'({adr, 2'b00}) + BA_W'(lo_eff);
        load       = {(we ? 8'h02 : 8'h03), byte_addr, tx_aligned};
        load_bits  = 7'(HDR_BITS) + 7'({nbytes, 3'b000});
    end

    // Transaction FSM, SCK divider, and MOSI/MISO shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            nbits    <= '0;
            grd_cnt  <= '0;
            sh       <= '0;
            rx       <= '0;
            we_q     <= 1'b0;
            dat_o    <= '0;
            ack      <= 1'b0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cyc) begin
                        we_q <= we;
                        if (we && (sel == 4'b0000)) begin
                            // Empty write: complete at once without touching the bus
                            state <= S_ACK;
                            ack   <= 1'b1;
                        end else begin
                            state    <= S_CMD;
                            spi_cs_n <= 1'b0;
                            spi_mosi <= load[SH_W-1];
                            sh       <= {load[SH_W-2:0], 1'b0};
                            nbits    <= load_bits;
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                end
                S_CMD, S_DATA: begin
                    // Rising SCK mid-bit; MISO is taken on this same edge
                    if (div_cnt == HALF_LAST) begin
                        spi_clk <= 1'b1;
                        rx      <= {rx[30:0], spi_miso};
                    end
                    if (div_cnt == FULL_LAST) begin
                        spi_clk <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 7'd1;
                        if (bit_cnt == nbits - 7'd1) begin
                            state    <= S_ACK;
                            ack      <= 1'b1;
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            if (!we_q) begin
                                dat_o <= rx_lanes;
                            end
                        end else begin
                            spi_mosi <= sh[SH_W-1];
                            sh       <= {sh[SH_W-2:0], 1'b0};
                            if (bit_cnt == 7'(HDR_BITS - 1)) begin
                                state <= S_DATA;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                S_ACK: begin
                    // The ACK cycle counts as the first CS-high cycle
                    state   <= S_GUARD;
                    grd_cnt <= 5'd2;
                end
                S_GUARD: begin
                    if (grd_cnt >= 5'(CSH_CYC)) begin
                        state <= S_IDLE;
                    end else begin
                        grd_cnt <= grd_cnt + 5'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: one instance at CLK_DIV=1/CSH_CYC=4 with
// an SPI slave model, and one at CLK_DIV=3 for SCK waveform timing.
module tb_spi_sram_ctrl;

`ifdef SPI_SRAM_BYTESWAP_EN
    localparam logic [31:0] RD1 = 32'h44332211;
    localparam logic [31:0] WR1 = 32'h020006AB;
    localparam logic [55:0] WR2 = 56'h020008D4C3B2A1;
    localparam logic [39:0] WR3 = 40'h02000D2211;
    localparam logic [55:0] WR4 = 56'h020040EFBEADDE;
    localparam logic [31:0] RD2 = 32'h960FC3A5;
    localparam logic [31:0] RD3 = 32'h3C2D1E0F;
`else
    localparam logic [31:0] RD1 = 32'h11223344;
    localparam logic [31:0] WR1 = 32'h020005AB;
    localparam logic [55:0] WR2 = 56'h020008A1B2C3D4;
    localparam logic [39:0] WR3 = 40'h02000D1122;
    localparam logic [55:0] WR4 = 56'h020040DEADBEEF;
    localparam logic [31:0] RD2 = 32'hA5C30F96;
    localparam logic [31:0] RD3 = 32'h0F1E2D3C;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] adr = '0;
    logic        we = 1'b0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic        cyc1 = 1'b0;
    logic        cyc3 = 1'b0;
    logic        miso1 = 1'b0;
    logic [31:0] dat_o1, dat_o3;
    logic        ack1, ack3;
    logic        sck1, mosi1, cs_n1;
    logic        sck3, mosi3, cs_n3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_sram_ctrl #(.ADDR_W(14), .ADDR_BYTES(2), .CLK_DIV(1), .CSH_CYC(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc1), .adr(adr), .we(we), .dat_i(dat_i),
        .sel(sel), .dat_o(dat_o1), .ack(ack1), .spi_miso(miso1),
        .spi_clk(sck1), .spi_mosi(mosi1), .spi_cs_n(cs_n1)
    );

    spi_sram_ctrl #(.ADDR_W(14), .ADDR_BYTES(2), .CLK_DIV(3), .CSH_CYC(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc3), .adr(adr), .we(we), .dat_i(dat_i),
        .sel(sel), .dat_o(dat_o3), .ack(ack3), .spi_miso(1'b0),
        .spi_clk(sck3), .spi_mosi(mosi3), .spi_cs_n(cs_n3)
    );

    // Slave model / monitor for dut1
    logic [31:0] miso_word = '0;
    logic [31:0] miso_tmp = '0;
    logic [63:0] cap1 = '0, done_cap1 = '0;
    logic        prev_sck1 = 1'b0, prev_cs1 = 1'b1;
    int rise1 = 0, done_rise1 = 0, hi_run1 = 0, last_hi1 = 0, low_cnt1 = 0;

    always @(negedge clk) begin
        if (!cs_n1) begin
            low_cnt1++;
            if (hi_run1 > 0) last_hi1 = hi_run1;
            hi_run1 = 0;
            if (sck1 && !prev_sck1) begin
                cap1 = {cap1[62:0], mosi1};
                rise1++;
            end
        end else begin
            hi_run1++;
            if (!prev_cs1) begin
                done_cap1  = cap1;
                done_rise1 = rise1;
            end
            cap1  = '0;
            rise1 = 0;
        end
        if (rise1 >= 24 && rise1 < 56) begin
            miso_tmp = miso_word << (rise1 - 24);
            miso1 = miso_tmp[31];
        end else begin
            miso1 = 1'b0;
        end
        prev_sck1 = sck1;
        prev_cs1  = cs_n1;
    end

    // Monitor for dut3: SCK phase lengths and MOSI stability while SCK high
    logic [63:0] cap3 = '0, done_cap3 = '0;
    logic        prev_sck3 = 1'b0, prev_cs3 = 1'b1, prev_mosi3 = 1'b0;
    int rise3 = 0, run3 = 0, bad3 = 0, done_rise3 = 0;

    always @(negedge clk) begin
        if (!cs_n3) begin
            if (sck3 == prev_sck3) run3++;
            else begin
                if (run3 != 3) bad3++;
                run3 = 1;
            end
            if (sck3 && prev_sck3 && (mosi3 != prev_mosi3)) bad3++;
            if (sck3 && !prev_sck3) begin
                cap3 = {cap3[62:0], mosi3};
                rise3++;
            end
        end else begin
            if (!prev_cs3) begin
                done_cap3  = cap3;
                done_rise3 = rise3;
            end
            run3  = 0;
            cap3  = '0;
            rise3 = 0;
        end
        prev_sck3  = sck3;
        prev_cs3   = cs_n3;
        prev_mosi3 = mosi3;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; n returns the cycle (acceptance = cycle 0) in which ack is seen
    task automatic txn(input int which, input logic w, input logic [13:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit hold,
                       output int n);
        repeat (6) @(posedge clk);
        @(negedge clk);
        adr = a; we = w; dat_i = d; sel = s;
        if (which == 1) cyc1 = 1'b1;
        else cyc3 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            cyc1 = 1'b0; cyc3 = 1'b0;
            adr = ~a; dat_i = ~d; sel = ~s;
        end
        n = 1;
        while ((((which == 1) ? ack1 : ack3) !== 1'b1) && (n < 3000)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        int lc;
        bit ack_seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst cs_n", 64'(cs_n1), 64'd1);
        check("rst spi_clk", 64'(sck1), 64'd0);
        check("rst mosi", 64'(mosi1), 64'd0);
        check("rst ack", 64'(ack1), 64'd0);
        check("rst dat_o", 64'(dat_o1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read word 4 -> byte address 0x0010
        miso_word = 32'h11223344;
        txn(1, 1'b0, 14'h0004, 32'h0, 4'hF, 1'b0, n);
        check("rd1 ack cycle", 64'(n), 64'd113);
        check("rd1 dat_o", 64'(dat_o1), 64'(RD1));
        @(negedge clk); #1;
        check("rd1 bits", 64'(done_rise1), 64'd56);
        check("rd1 header", 64'(done_cap1[55:32]), 64'h030010);

        // Single-byte write
        txn(1, 1'b1, 14'h0001, 32'h00AB0000, 4'b0100, 1'b0, n);
        check("wr1 ack cycle", 64'(n), 64'd65);
        check("wr1 dat_o held", 64'(dat_o1), 64'(RD1));
        @(negedge clk); #1;
        check("wr1 bits", 64'(done_rise1), 64'd32);
        check("wr1 frame", 64'(done_cap1[31:0]), 64'(WR1));

        // Non-contiguous select spans the whole word
        txn(1, 1'b1, 14'h0002, 32'hA1B2C3D4, 4'b1001, 1'b0, n);
        check("wr2 ack cycle", 64'(n), 64'd113);
        @(negedge clk); #1;
        check("wr2 frame", 64'(done_cap1[55:0]), 64'(WR2));

        // Two middle bytes
        txn(1, 1'b1, 14'h0003, 32'h00112200, 4'b0110, 1'b0, n);
        check("wr3 ack cycle", 64'(n), 64'd81);
        @(negedge clk); #1;
        check("wr3 bits", 64'(done_rise1), 64'd40);
        check("wr3 frame", 64'(done_cap1[39:0]), 64'(WR3));

        // Empty write: immediate ack, no chip select
        lc = low_cnt1;
        txn(1, 1'b1, 14'h0005, 32'hFFFFFFFF, 4'b0000, 1'b0, n);
        check("wr0 ack cycle", 64'(n), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("wr0 cs never low", 64'(low_cnt1 - lc), 64'd0);
        check("wr0 dat_o held", 64'(dat_o1), 64'(RD1));

        // Full write at CLK_DIV=3
        txn(3, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, 1'b0, n);
        check("div3 ack cycle", 64'(n), 64'd337);
        @(negedge clk); #1;
        check("div3 bits", 64'(done_rise3), 64'd56);
        check("div3 sck phases", 64'(bad3), 64'd0);
        check("div3 frame", 64'(done_cap3[55:0]), 64'(WR4));

        // Reset during a read
        miso_word = 32'hA5C30F96;
        repeat (6) @(posedge clk);
        @(negedge clk);
        adr = 14'h3FFF; we = 1'b0; sel = 4'hF; cyc1 = 1'b1;
        @(posedge clk);
        #1;
        cyc1 = 1'b0;
        m = 0;
        while (rise1 < 30 && m < 500) begin
            @(posedge clk);
            #1;
            m++;
        end
        check("abort reached bit 30", 64'(rise1), 64'd30);
        rst_n = 1'b0;
        #1;
        check("abort cs_n", 64'(cs_n1), 64'd1);
        check("abort spi_clk", 64'(sck1), 64'd0);
        check("abort dat_o", 64'(dat_o1), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lc = low_cnt1;
        ack_seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (ack1 === 1'b1) ack_seen = 1'b1;
        end
        check("abort no ack", 64'(ack_seen), 64'd0);
        check("abort cs idle", 64'(low_cnt1 - lc), 64'd0);

        txn(1, 1'b0, 14'h3FFF, 32'h0, 4'hF, 1'b0, n);
        check("rd2 ack cycle", 64'(n), 64'd113);
        check("rd2 dat_o", 64'(dat_o1), 64'(RD2));
        @(negedge clk); #1;
        check("rd2 header", 64'(done_cap1[55:32]), 64'h03FFFC);

        // Back-to-back reads with cyc held high
        miso_word = 32'h0F1E2D3C;
        txn(1, 1'b0, 14'h0004, 32'h0, 4'hF, 1'b1, n);
        check("b2b first ack cycle", 64'(n), 64'd113);
        m = 0;
        while (cs_n1 !== 1'b0 && m < 50) begin
            @(posedge clk);
            #1;
            m++;
        end
        cyc1 = 1'b0;
        check("b2b restart cycles", 64'(m), 64'd5);
        n = 1;
        while (ack1 !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b second ack cycle", 64'(n), 64'd113);
        check("b2b dat_o", 64'(dat_o1), 64'(RD3));
        check("b2b cs high gap", 64'(last_hi1), 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
